// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the word-addressed data memory.
// Word/byte loads and stores; byte stores use read-modify-write.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_enable,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state, state_next;
  logic                  cap_write, cap_byte;
  logic [1:0]            cap_lane;
  logic [ADDR_WIDTH-1:0] cap_index;
  logic [DATA_WIDTH-1:0] cap_wdata, buffer;
  logic                  accept, req_fault;
  logic [ADDR_WIDTH-1:0] req_index;
  logic [DATA_WIDTH-1:0] lane_merge, rdata_lane, load_result;

  assign req_index = req_addr >> 2;
  assign req_fault = (!req_byte && (req_addr[1:0] != 2'b00)) ||
                     (req_index >= ADDR_WIDTH'(MEM_DEPTH));
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault)                  state_next = RESP;
          else if (!req_write || req_byte) state_next = READ;
          else                            state_next = WRITE;
        end
      end
      READ:    state_next = cap_write ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are gated by reset directly because the memory writes level-sensitively.
  always_comb begin
    mem_enable = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (!reset) begin
      case (state)
        READ:    begin mem_enable = 1'b1; mem_read  = 1'b1; end
        WRITE:   begin mem_enable = 1'b1; mem_write = 1'b1; end
        default: ;
      endcase
    end
    resp_valid = (state == RESP);
  end

  always_comb begin
    lane_merge = buffer;
    rdata_lane = '0;
    case (cap_lane)
      2'd0: begin lane_merge[7:0]   = cap_wdata[7:0]; rdata_lane[7:0] = mem_rdata[7:0];   end
      2'd1: begin lane_merge[15:8]  = cap_wdata[7:0]; rdata_lane[7:0] = mem_rdata[15:8];  end
      2'd2: begin lane_merge[23:16] = cap_wdata[7:0]; rdata_lane[7:0] = mem_rdata[23:16]; end
      default: begin lane_merge[31:24] = cap_wdata[7:0]; rdata_lane[7:0] = mem_rdata[31:24]; end
    endcase
  end

  assign load_result = cap_byte ? rdata_lane : mem_rdata;
  assign mem_addr    = cap_index;
  assign mem_wdata   = cap_byte ? lane_merge : cap_wdata;

  // RESP is only entered from IDLE on a fault, from READ on a load, from WRITE on a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_write  <= 1'b0;
      cap_byte   <= 1'b0;
      cap_lane   <= 2'd0;
      cap_index  <= '0;
      cap_wdata  <= '0;
      buffer     <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_byte  <= req_byte;
        cap_lane  <= req_addr[1:0];
        cap_index <= req_index;
        cap_wdata <= req_wdata;
      end
      if (state == READ) buffer <= mem_rdata;
      if ((state != RESP) && (state_next == RESP)) begin
        resp_fault <= (state == IDLE);
        resp_rdata <= (state == READ) ? load_result : '0;
      end
    end
  end

endmodule
